// File: rtl/radar_burst_scheduler.sv
// Burst scheduler for the radar pulse controller: PRP-timed triggers grouped into
// bursts separated by idle gaps, with overrun flagging and abort that never drops an in-flight pulse.
module radar_burst_scheduler #(
    parameter int CNT_W = 32,
    parameter int IDX_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [CNT_W-1:0] cfg_prp,
    input  logic [IDX_W-1:0] cfg_num_pulses,
    input  logic [CNT_W-1:0] cfg_burst_gap,
    input  logic [IDX_W-1:0] cfg_num_bursts,
    input  logic             start,
    input  logic             stop,
    input  logic             pulse_ready,
    input  logic             pulse_done,
    output logic             pulse_trig,
    output logic             busy,
    output logic [IDX_W-1:0] pulse_idx,
    output logic [IDX_W-1:0] burst_idx,
    output logic             burst_done,
    output logic             seq_done,
    output logic             overrun
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_TRIG      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] prp_cnt_q, prp_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] prp_sh_q, prp_sh_d;
    logic [CNT_W-1:0] gap_sh_q, gap_sh_d;
    logic [IDX_W-1:0] npulse_sh_q, npulse_sh_d;
    logic [IDX_W-1:0] nburst_sh_q, nburst_sh_d;
    logic [IDX_W-1:0] pulse_idx_q, pulse_idx_d;
    logic [IDX_W-1:0] burst_idx_q, burst_idx_d;
    logic             overrun_q, overrun_d;
    logic             stop_pend_q, stop_pend_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             burst_done_q, burst_done_d;
    logic             seq_done_q, seq_done_d;

    logic [IDX_W-1:0] pulse_inc_s;
    logic [IDX_W-1:0] burst_inc_s;
    logic             burst_end_s;
    logic             last_burst_s;
    logic [CNT_W-1:0] prp_load_s;

    assign pulse_inc_s  = pulse_idx_q + IDX_ONE;
    assign burst_inc_s  = burst_idx_q + IDX_ONE;
    assign burst_end_s  = (npulse_sh_q != '0) && (pulse_inc_s == npulse_sh_q);
    assign last_burst_s = (nburst_sh_q != '0) && (burst_inc_s == nburst_sh_q);
    // A programmed period of zero behaves like a period of one.
    assign prp_load_s   = (prp_sh_q == '0) ? '0 : (prp_sh_q - CNT_ONE);

    // Next-state and next-output computation for the scheduler.
    always_comb begin
        state_d      = state_q;
        prp_cnt_d    = (prp_cnt_q != '0) ? (prp_cnt_q - CNT_ONE) : '0;
        gap_cnt_d    = gap_cnt_q;
        prp_sh_d     = prp_sh_q;
        gap_sh_d     = gap_sh_q;
        npulse_sh_d  = npulse_sh_q;
        nburst_sh_d  = nburst_sh_q;
        pulse_idx_d  = pulse_idx_q;
        burst_idx_d  = burst_idx_q;
        overrun_d    = overrun_q;
        stop_pend_d  = stop_pend_q;
        burst_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    prp_sh_d    = cfg_prp;
                    gap_sh_d    = cfg_burst_gap;
                    npulse_sh_d = cfg_num_pulses;
                    nburst_sh_d = cfg_num_bursts;
                    pulse_idx_d = '0;
                    burst_idx_d = '0;
                    overrun_d   = 1'b0;
                    stop_pend_d = 1'b0;
                    prp_cnt_d   = '0;
                    state_d     = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_d = S_FINISH;
                end else if (pulse_ready && (prp_cnt_q == '0)) begin
                    prp_cnt_d = prp_load_s;
                    state_d   = S_TRIG;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_TRIG: begin
                stop_pend_d = stop_pend_q | stop;
                state_d     = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (pulse_done) begin
                    if (burst_end_s) begin
                        burst_done_d = 1'b1;
                        pulse_idx_d  = '0;
                        burst_idx_d  = burst_inc_s;
                    end else begin
                        pulse_idx_d = pulse_inc_s;
                    end
                    // The finished pulse is always counted, even when aborting.
                    if (stop_pend_q || stop || (burst_end_s && last_burst_s)) begin
                        state_d = S_FINISH;
                    end else if (burst_end_s) begin
                        gap_cnt_d = gap_sh_q;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_ARM;
                    end
                end else begin
                    stop_pend_d = stop_pend_q | stop;
                    overrun_d   = overrun_q | (prp_cnt_q == '0);
                    state_d     = S_WAIT_DONE;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_FINISH;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_ARM;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_ONE;
                    state_d   = S_GAP;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        trig_d     = (state_d == S_TRIG);
        busy_d     = (state_d != S_IDLE);
        seq_done_d = (state_d == S_FINISH);
    end

    // State, shadow configuration, counters and registered outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            prp_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            prp_sh_q     <= '0;
            gap_sh_q     <= '0;
            npulse_sh_q  <= '0;
            nburst_sh_q  <= '0;
            pulse_idx_q  <= '0;
            burst_idx_q  <= '0;
            overrun_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prp_cnt_q    <= prp_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            prp_sh_q     <= prp_sh_d;
            gap_sh_q     <= gap_sh_d;
            npulse_sh_q  <= npulse_sh_d;
            nburst_sh_q  <= nburst_sh_d;
            pulse_idx_q  <= pulse_idx_d;
            burst_idx_q  <= burst_idx_d;
            overrun_q    <= overrun_d;
            stop_pend_q  <= stop_pend_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
            burst_done_q <= burst_done_d;
            seq_done_q   <= seq_done_d;
        end
    end

    assign pulse_trig = trig_q;
    assign busy       = busy_q;
    assign pulse_idx  = pulse_idx_q;
    assign burst_idx  = burst_idx_q;
    assign burst_done = burst_done_q;
    assign seq_done   = seq_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_radar_burst_scheduler.sv
// Bench for radar_burst_scheduler: a time-based model predicts every output each cycle,
// and directed scenarios pin trigger spacing and sequence end times to hand-computed values.
module tb_radar_burst_scheduler;

    logic        aclk;
    logic        areset;
    logic [31:0] cfg_prp;
    logic [15:0] cfg_num_pulses;
    logic [31:0] cfg_burst_gap;
    logic [15:0] cfg_num_bursts;
    logic        start;
    logic        stop;
    logic        pulse_ready;
    logic        pulse_done;
    logic        pulse_trig;
    logic        busy;
    logic [15:0] pulse_idx;
    logic [15:0] burst_idx;
    logic        burst_done;
    logic        seq_done;
    logic        overrun;

    int cyc       = 0;
    int total_cnt = 0;
    int pass_cnt  = 0;
    int done_lat  = 10;
    int done_cd   = 0;
    int trig_log[$];
    int sd_log[$];

    // Model state, expressed as times of events rather than controller states.
    int          m_phase = 0;   // 0 idle, 1 sequence running, 2 ending this cycle
    bit          m_inflight = 1'b0;
    int          m_t = 0;
    int          m_earliest = 0;
    int          m_P = 1;
    int          m_G = 0;
    logic [15:0] m_np = 16'd0;
    logic [15:0] m_nb = 16'd0;
    logic [15:0] m_pidx = 16'd0;
    logic [15:0] m_bidx = 16'd0;
    bit          m_ovr = 1'b0;
    bit          m_stop_pend = 1'b0;

    logic        exp_trig = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_bd = 1'b0;
    logic        exp_sd = 1'b0;
    logic        exp_ovr = 1'b0;
    logic [15:0] exp_pidx = 16'd0;
    logic [15:0] exp_bidx = 16'd0;

    radar_burst_scheduler dut (
        .aclk           (aclk),
        .areset         (areset),
        .cfg_prp        (cfg_prp),
        .cfg_num_pulses (cfg_num_pulses),
        .cfg_burst_gap  (cfg_burst_gap),
        .cfg_num_bursts (cfg_num_bursts),
        .start          (start),
        .stop           (stop),
        .pulse_ready    (pulse_ready),
        .pulse_done     (pulse_done),
        .pulse_trig     (pulse_trig),
        .busy           (busy),
        .pulse_idx      (pulse_idx),
        .burst_idx      (burst_idx),
        .burst_done     (burst_done),
        .seq_done       (seq_done),
        .overrun        (overrun)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        total_cnt++;
        if (got == want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, got, want);
        end
    endtask

    // Consume the inputs of cycle c and predict the outputs of cycle c+1.
    task automatic model_step(input int c);
        bit end_b;
        bit last_b;
        exp_trig = 1'b0;
        exp_bd   = 1'b0;
        exp_sd   = 1'b0;
        if (m_phase == 0) begin
            if (start) begin
                m_P = (cfg_prp == 32'd0) ? 1 : int'(cfg_prp);
                m_G = int'(cfg_burst_gap);
                m_np = cfg_num_pulses;
                m_nb = cfg_num_bursts;
                m_pidx = 16'd0;
                m_bidx = 16'd0;
                m_ovr = 1'b0;
                m_stop_pend = 1'b0;
                m_inflight = 1'b0;
                m_earliest = c + 2;
                m_phase = 1;
            end
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_inflight) begin
            if (c == m_t) begin
                if (stop) m_stop_pend = 1'b1;
            end else if (pulse_done) begin
                m_pidx = m_pidx + 16'd1;
                end_b  = (m_np != 16'd0) && (m_pidx == m_np);
                last_b = 1'b0;
                if (end_b) begin
                    m_pidx = 16'd0;
                    m_bidx = m_bidx + 16'd1;
                    exp_bd = 1'b1;
                    last_b = (m_nb != 16'd0) && (m_bidx == m_nb);
                end
                m_inflight = 1'b0;
                if (stop || m_stop_pend || last_b) begin
                    m_phase = 2;
                    exp_sd  = 1'b1;
                end else if (end_b) begin
                    m_earliest = imax(m_t + m_P, c + 3 + m_G);
                end else begin
                    m_earliest = imax(m_t + m_P, c + 2);
                end
            end else begin
                if (stop) m_stop_pend = 1'b1;
                if (c >= m_t + imax(m_P - 1, 1)) m_ovr = 1'b1;
            end
        end else begin
            if (stop) begin
                m_phase = 2;
                exp_sd  = 1'b1;
            end else if (pulse_ready && (c + 1 >= m_earliest)) begin
                exp_trig   = 1'b1;
                m_inflight = 1'b1;
                m_t        = c + 1;
            end
        end
        exp_busy = (m_phase != 0);
        exp_pidx = m_pidx;
        exp_bidx = m_bidx;
        exp_ovr  = m_ovr;
    endtask

    initial begin
        forever begin
            @(posedge aclk);
            if (areset) begin
                m_phase = 0; m_inflight = 1'b0; m_pidx = 16'd0; m_bidx = 16'd0;
                m_ovr = 1'b0; m_stop_pend = 1'b0;
                exp_trig = 1'b0; exp_busy = 1'b0; exp_bd = 1'b0; exp_sd = 1'b0;
                exp_ovr = 1'b0; exp_pidx = 16'd0; exp_bidx = 16'd0;
            end else begin
                model_step(cyc);
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            chk("pulse_trig", int'(pulse_trig), int'(exp_trig));
            chk("busy", int'(busy), int'(exp_busy));
            chk("burst_done", int'(burst_done), int'(exp_bd));
            chk("seq_done", int'(seq_done), int'(exp_sd));
            chk("overrun", int'(overrun), int'(exp_ovr));
            chk("pulse_idx", int'(pulse_idx), int'(exp_pidx));
            chk("burst_idx", int'(burst_idx), int'(exp_bidx));
            if (pulse_trig === 1'b1) trig_log.push_back(cyc);
            if (seq_done === 1'b1) sd_log.push_back(cyc);
        end
    end

    // Pulse controller stand-in: pulse_done exactly done_lat cycles after each trigger.
    initial begin
        pulse_done = 1'b0;
        forever begin
            @(negedge aclk);
            #2;
            if (areset) begin
                done_cd    = 0;
                pulse_done = 1'b0;
            end else begin
                pulse_done = (done_cd == 1);
                if (done_cd > 0) done_cd--;
                if (pulse_trig === 1'b1) done_cd = done_lat;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
        #1;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic launch(output int s);
        trig_log.delete();
        sd_log.delete();
        start = 1'b1;
        s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic setup(input int prp, input int np, input int nb, input int gap, input int lat);
        cfg_prp        = 32'(prp);
        cfg_num_pulses = 16'(np);
        cfg_num_bursts = 16'(nb);
        cfg_burst_gap  = 32'(gap);
        done_lat       = lat;
    endtask

    function automatic int first_or(input int q[$], input int base);
        return (q.size() > 0) ? q[0] - base : -1;
    endfunction

    function automatic int gap_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] - q[i-1] : -1;
    endfunction

    initial begin
        int s;
        areset = 1'b1; start = 1'b0; stop = 1'b0; pulse_ready = 1'b1;
        setup(100, 4, 1, 0, 10);
        tick(3);
        areset = 1'b0;
        tick(2);

        // Single burst of four pulses at PRP 100.
        setup(100, 4, 1, 0, 10);
        launch(s);
        go_to(s + 350);
        chk("t1_trig_count", trig_log.size(), 4);
        chk("t1_first_trig", first_or(trig_log, s), 2);
        for (int i = 1; i < 4; i++) chk("t1_spacing", gap_at(trig_log, i), 100);
        chk("t1_seq_done_time", first_or(sd_log, s), 313);
        chk("t1_burst_idx", int'(burst_idx), 1);
        chk("t1_overrun", int'(overrun), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_model_bidx", int'(m_bidx), 1);

        // Two bursts of three with a 50-cycle gap.
        setup(20, 3, 2, 50, 10);
        launch(s);
        go_to(s + 200);
        chk("t2_trig_count", trig_log.size(), 6);
        chk("t2_intra_spacing", gap_at(trig_log, 1), 20);
        chk("t2_inter_spacing", gap_at(trig_log, 3), 63);
        chk("t2_seq_done_time", first_or(sd_log, s), 156);
        chk("t2_burst_idx", int'(burst_idx), 2);

        // Late pulse_done causes overrun, which persists until the next start.
        setup(20, 2, 1, 0, 30);
        launch(s);
        go_to(s + 90);
        chk("t3_trig_count", trig_log.size(), 2);
        chk("t3_late_spacing", gap_at(trig_log, 1), 32);
        chk("t3_seq_done_time", first_or(sd_log, s), 65);
        chk("t3_overrun_sticky", int'(overrun), 1);
        setup(20, 1, 1, 0, 5);
        launch(s);
        chk("t3_overrun_cleared", int'(overrun), 0);
        go_to(s + 40);

        // Continuous mode, stop during an in-flight pulse.
        setup(10, 0, 0, 0, 5);
        launch(s);
        go_to(s + 4);
        pulse_stop();
        go_to(s + 40);
        chk("t4_trig_count", trig_log.size(), 1);
        chk("t4_seq_done_time", first_or(sd_log, s), 8);
        chk("t4_pulse_idx", int'(pulse_idx), 1);

        // Stop during the inter-burst gap finishes at once.
        setup(10, 1, 0, 50, 5);
        launch(s);
        go_to(s + 20);
        pulse_stop();
        go_to(s + 40);
        chk("t4b_trig_count", trig_log.size(), 1);
        chk("t4b_seq_done_time", first_or(sd_log, s), 21);
        chk("t4b_burst_idx", int'(burst_idx), 1);

        // Ready held low past PRP expiry; config change while busy is ignored.
        setup(10, 2, 1, 0, 3);
        launch(s);
        go_to(s + 6);
        pulse_ready = 1'b0;
        go_to(s + 10);
        cfg_prp = 32'd3;
        go_to(s + 46);
        pulse_ready = 1'b1;
        go_to(s + 70);
        chk("t5_trig_count", trig_log.size(), 2);
        chk("t5_held_spacing", gap_at(trig_log, 1), 45);
        chk("t5_seq_done_time", first_or(sd_log, s), 51);

        // Asynchronous reset in the middle of a pulse, then a normal restart.
        setup(100, 4, 1, 0, 50);
        launch(s);
        go_to(s + 10);
        areset = 1'b1;
        #1;
        chk("t6_rst_trig", int'(pulse_trig), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_pidx", int'(pulse_idx), 0);
        chk("t6_rst_bidx", int'(burst_idx), 0);
        chk("t6_rst_bdone", int'(burst_done), 0);
        chk("t6_rst_sdone", int'(seq_done), 0);
        chk("t6_rst_ovr", int'(overrun), 0);
        tick(2);
        areset = 1'b0;
        tick(2);
        setup(10, 2, 1, 0, 3);
        launch(s);
        go_to(s + 40);
        chk("t6_trig_count", trig_log.size(), 2);
        chk("t6_first_trig", first_or(trig_log, s), 2);
        chk("t6_seq_done_time", first_or(sd_log, s), 16);
        chk("t6_burst_idx", int'(burst_idx), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
